mem_arbiter: RTL and testbench
==============================

MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 Parameter: TIMEOUT_CYCLES, default 16, MAck wait limit in cycles (used only with MEM_ARB_TIMEOUT_EN).
REQ-002 Port: clk  input  1  single clock; all state updates on rising edge.
REQ-003 Port: reset  input  1  asynchronous, active-high reset.
REQ-004 Port: IReq  input  1  fetch request; held high until IValid.
REQ-005 Port: IAdr  input  32  fetch address.
REQ-006 Port: IRdata  output  32  registered fetched instruction.
REQ-007 Port: IValid  output  1  one-cycle fetch completion pulse.
REQ-008 Port: DReq  input  1  data request; held high until DValid.
REQ-009 Port: DWe, DAdr, DWdata  input  1/32/32  data write-enable, address, write data.
REQ-010 Port: DRdata  output  32  registered load data.
REQ-011 Port: DValid  output  1  one-cycle data completion pulse.
REQ-012 Port: StallMem  output  1  stall request to hazard unit.
REQ-013 Port: MReq, MWe, MAdr, MWdata  output  1/1/32/32  single-port memory request bus, all registered.
REQ-014 Port: MRdata, MAck  input  32/1  memory read data and acknowledge.
REQ-015 Port: TimeoutErr  output  1  sticky timeout flag.

Function
REQ-016 FSM states SHALL be IDLE, IACC, DACC, RESP.
REQ-017 IDLE: if DReq, next state SHALL be DACC; else if IReq, next state SHALL be IACC; else stay in IDLE. Data has fixed priority.
REQ-018 On IDLE->xACC, the block SHALL register MReq=1 and the winner's address. For data it SHALL also register MWe=DWe and MWdata=DWdata. For fetch it SHALL register MWe=0 and MWdata=0.
REQ-019 In xACC, MReq, MWe, MAdr and MWdata SHALL stay stable until the cycle MAck is sampled high.
REQ-020 On MAck in IACC, the block SHALL capture MRdata into IRdata. On MAck in DACC with MWe=0, it SHALL capture MRdata into DRdata; on a write (MWe=1), DRdata SHALL keep its value. In both cases MReq SHALL drop to 0 and the FSM SHALL enter RESP.
REQ-021 RESP: the block SHALL assert IValid or DValid for exactly one cycle, matching the served port, then return to IDLE. Requests SHALL be ignored while in RESP.
REQ-022 Latency: a request seen in IDLE at cycle n drives MReq at n+1. With MAck at cycle n+1+k, Valid SHALL pulse at n+2+k.
REQ-023 StallMem SHALL be combinational: (IReq & ~IValid) | (DReq & ~DValid).
REQ-024 IReq and DReq high together in IDLE: data SHALL be served first. Fetch SHALL be served on the next IDLE, with no fetch starvation while DReq is low.
REQ-025 MAck while in IDLE or RESP SHALL be ignored.

Reset
REQ-026 While reset is high, the FSM SHALL be IDLE, and MReq, MWe, IValid, DValid and TimeoutErr SHALL be 0. MAdr, MWdata, IRdata and DRdata SHALL be 32'h0.
REQ-027 Reset mid-transaction SHALL drop MReq asynchronously with no Valid pulse. A late MAck after reset release SHALL be ignored.

Configuration
REQ-028 Macro MEM_ARB_TIMEOUT_EN defined: a counter SHALL count xACC cycles with MAck low. On reaching TIMEOUT_CYCLES, the FSM SHALL abort to RESP, load 32'hDEADBEEF into the served Rdata, pulse Valid, and set TimeoutErr (sticky until reset). The counter SHALL clear on entering xACC.
REQ-029 Macro undefined: xACC SHALL wait indefinitely, no counter SHALL be built, and TimeoutErr SHALL be tied 0.

Verification
REQ-030 IReq=1, IAdr=32'h100, MAck asserted in the first MReq cycle, MRdata=32'hE3A00001 -> MReq at n+1, IValid at n+2, IRdata=32'hE3A00001.
REQ-031 IReq and DReq both high at cycle n, DAdr=32'h200, DWe=0, MAck after 2 wait cycles -> MAdr=32'h200 first, DValid, then MAdr=IAdr, then IValid. StallMem stays high throughout.
REQ-032 DReq=1, DWe=1, DWdata=32'hCAFEF00D -> MWe=1, MWdata=32'hCAFEF00D. DRdata is unchanged and DValid pulses once.
REQ-033 Reset asserted during DACC with MReq=1 -> MReq=0 immediately. After release, a stray MAck produces no DValid.
REQ-034 With MEM_ARB_TIMEOUT_EN and TIMEOUT_CYCLES=16, DReq issued and MAck held low -> abort after 16 cycles, DRdata=32'hDEADBEEF, DValid pulse, TimeoutErr=1 held until reset.
REQ-035 Back-to-back IReq held across RESP -> exactly one IValid per transaction, and at least one IDLE cycle between MReq pulses.

Source files
------------

// File: rtl/mem_arbiter_if.sv
// mem_arbiter_if: fetch/data request ports plus the single-port memory bus
interface mem_arbiter_if;
  logic        IReq;
  logic [31:0] IAdr;
  logic [31:0] IRdata;
  logic        IValid;
  logic        DReq;
  logic        DWe;
  logic [31:0] DAdr;
  logic [31:0] DWdata;
  logic [31:0] DRdata;
  logic        DValid;
  logic        StallMem;
  logic        MReq;
  logic        MWe;
  logic [31:0] MAdr;
  logic [31:0] MWdata;
  logic [31:0] MRdata;
  logic        MAck;
  logic        TimeoutErr;
  modport slave (
    input  IReq, IAdr, DReq, DWe, DAdr, DWdata, MRdata, MAck,
    output IRdata, IValid, DRdata, DValid, StallMem, MReq, MWe, MAdr, MWdata, TimeoutErr
  );
  modport master (
    output IReq, IAdr, DReq, DWe, DAdr, DWdata, MRdata, MAck,
    input  IRdata, IValid, DRdata, DValid, StallMem, MReq, MWe, MAdr, MWdata, TimeoutErr
  );
endinterface

// File: rtl/mem_arbiter.sv
// mem_arbiter: fetch/data arbiter onto one memory port, data has fixed priority.
// Define MEM_ARB_TIMEOUT_EN to abort stuck accesses after TIMEOUT_CYCLES with 32'hDEADBEEF.
module mem_arbiter #(
  parameter int TIMEOUT_CYCLES = 16
) (
  input logic         clk,
  input logic         reset,
  mem_arbiter_if.slave bus
);
  typedef enum logic [1:0] {IDLE, IACC, DACC, RESP} state_t;
  state_t      state_q, state_d;
  logic        m_req_q, m_req_d, m_we_q, m_we_d;
  logic        i_valid_q, i_valid_d, d_valid_q, d_valid_d;
  logic [31:0] m_adr_q, m_adr_d, m_wdata_q, m_wdata_d;
  logic [31:0] i_rdata_q, i_rdata_d, d_rdata_q, d_rdata_d;
  logic        acc, abort, done;
  logic [31:0] rdata;
  assign acc = state_q == IACC || state_q == DACC;
`ifdef MEM_ARB_TIMEOUT_EN
  localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
  logic [CW-1:0] cnt_q, cnt_d;
  logic          t_err_q, t_err_d;
  // counter sits at zero outside xACC, so it is clear on every xACC entry
  assign abort   = acc && !bus.MAck && cnt_q == CW'(TIMEOUT_CYCLES - 1);
  assign cnt_d   = (acc && !bus.MAck) ? cnt_q + 1'b1 : '0;
  assign t_err_d = t_err_q | abort;
  assign bus.TimeoutErr = t_err_q;
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      cnt_q   <= '0;
      t_err_q <= 1'b0;
    end else begin
      cnt_q   <= cnt_d;
      t_err_q <= t_err_d;
    end
`else
  localparam int unused_timeout_cycles = TIMEOUT_CYCLES;
  assign abort = 1'b0;
  assign bus.TimeoutErr = 1'b0;
`endif
  assign done  = acc && (bus.MAck || abort);
  assign rdata = abort ? 32'hDEADBEEF : bus.MRdata;
  always_comb begin
    state_d   = state_q;
    m_req_d   = m_req_q;
    m_we_d    = m_we_q;
    m_adr_d   = m_adr_q;
    m_wdata_d = m_wdata_q;
    i_rdata_d = i_rdata_q;
    d_rdata_d = d_rdata_q;
    i_valid_d = 1'b0;
    d_valid_d = 1'b0;
    if (state_q == IDLE && (bus.DReq || bus.IReq)) begin
      state_d   = bus.DReq ? DACC : IACC;
      m_req_d   = 1'b1;
      m_we_d    = bus.DReq & bus.DWe;
      m_adr_d   = bus.DReq ? bus.DAdr : bus.IAdr;
      m_wdata_d = bus.DReq ? bus.DWdata : 32'h0;
    end else if (done) begin
      state_d   = RESP;
      m_req_d   = 1'b0;
      i_valid_d = state_q == IACC;
      d_valid_d = state_q == DACC;
      i_rdata_d = state_q == IACC ? rdata : i_rdata_q;
      d_rdata_d = (state_q == DACC && (abort || !m_we_q)) ? rdata : d_rdata_q;
    end else if (state_q == RESP) begin
      state_d   = IDLE;
    end
  end
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      state_q   <= IDLE;
      m_req_q   <= 1'b0;
      m_we_q    <= 1'b0;
      m_adr_q   <= 32'h0;
      m_wdata_q <= 32'h0;
      i_rdata_q <= 32'h0;
      d_rdata_q <= 32'h0;
      i_valid_q <= 1'b0;
      d_valid_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      m_req_q   <= m_req_d;
      m_we_q    <= m_we_d;
      m_adr_q   <= m_adr_d;
      m_wdata_q <= m_wdata_d;
      i_rdata_q <= i_rdata_d;
      d_rdata_q <= d_rdata_d;
      i_valid_q <= i_valid_d;
      d_valid_q <= d_valid_d;
    end
  assign bus.MReq     = m_req_q;
  assign bus.MWe      = m_we_q;
  assign bus.MAdr     = m_adr_q;
  assign bus.MWdata   = m_wdata_q;
  assign bus.IRdata   = i_rdata_q;
  assign bus.DRdata   = d_rdata_q;
  assign bus.IValid   = i_valid_q;
  assign bus.DValid   = d_valid_q;
  assign bus.StallMem = (bus.IReq & ~i_valid_q) | (bus.DReq & ~d_valid_q);
endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter: vector table, hand sequences and random transactions against a transaction-level model
module tb_mem_arbiter;
  logic clk = 1'b0;
  logic reset = 1'b1;
  int errors = 0;
  int checks = 0;
  logic [31:0] exp_ir = 32'h0;
  logic [31:0] exp_dr = 32'h0;
  mem_arbiter_if b();
  mem_arbiter dut (.clk(clk), .reset(reset), .bus(b));
  always #5 clk = ~clk;

  typedef struct {
    logic        is_d;
    logic        we;
    logic [31:0] adr;
    logic [31:0] wd;
    logic [31:0] rd;
    int          waits;
    logic [31:0] exp_rd;
  } vec_t;

  task automatic chk32(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic chk1(input string name, input logic act, input logic exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %b expected %b", name, act, exp);
    end
  endtask

  // one isolated transaction from IDLE; memory acks after `waits` extra MReq cycles
  task automatic run_txn(input logic is_d, input logic we, input logic [31:0] adr, input logic [31:0] wd,
                         input logic [31:0] rd, input int waits, input logic [31:0] exp_rd);
    @(negedge clk);
    if (is_d) begin
      b.DReq = 1'b1; b.DWe = we; b.DAdr = adr; b.DWdata = wd;
    end else begin
      b.IReq = 1'b1; b.IAdr = adr;
    end
    #1;
    chk1("stall_on_req", b.StallMem, 1'b1);
    chk1("mreq_not_yet", b.MReq, 1'b0);
    for (int i = 0; i <= waits; i++) begin
      @(negedge clk);
      chk1("mreq_held", b.MReq, 1'b1);
      chk32("madr", b.MAdr, adr);
      chk1("mwe", b.MWe, is_d & we);
      chk32("mwdata", b.MWdata, is_d ? wd : 32'h0);
      chk1("no_valid_in_acc", b.IValid | b.DValid, 1'b0);
      b.MAck = (i == waits);
      b.MRdata = (i == waits) ? rd : $urandom;
    end
    @(negedge clk);
    b.MAck = 1'b1;
    b.MRdata = $urandom;
    chk1("ivalid", b.IValid, !is_d);
    chk1("dvalid", b.DValid, is_d);
    chk1("mreq_drop", b.MReq, 1'b0);
    chk32("irdata", b.IRdata, is_d ? exp_ir : exp_rd);
    chk32("drdata", b.DRdata, is_d ? exp_rd : exp_dr);
    b.IReq = 1'b0;
    b.DReq = 1'b0;
    @(negedge clk);
    b.MAck = 1'b0;
    chk1("valid_once", b.IValid | b.DValid, 1'b0);
    chk1("stall_idle", b.StallMem, 1'b0);
    chk32("irdata_hold", b.IRdata, is_d ? exp_ir : exp_rd);
    chk32("drdata_hold", b.DRdata, is_d ? exp_rd : exp_dr);
    if (is_d) exp_dr = exp_rd;
    else exp_ir = exp_rd;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t vecs[6];
    logic [1:0] exp_mreq_v;
    logic [31:0] rd1, rd2;
    int n;
    vecs[0] = '{1'b0, 1'b0, 32'h100,      32'h0,        32'hE3A00001, 0, 32'hE3A00001};
    vecs[1] = '{1'b1, 1'b0, 32'h200,      32'h0,        32'h11112222, 2, 32'h11112222};
    vecs[2] = '{1'b1, 1'b1, 32'h204,      32'hCAFEF00D, 32'h55555555, 1, 32'h11112222};
    vecs[3] = '{1'b0, 1'b0, 32'h104,      32'h0,        32'hA5A5A5A5, 3, 32'hA5A5A5A5};
    vecs[4] = '{1'b1, 1'b0, 32'hFFFFFFFC, 32'h0,        32'hFFFFFFFF, 0, 32'hFFFFFFFF};
    vecs[5] = '{1'b1, 1'b1, 32'h0,        32'h0,        32'h77777777, 0, 32'hFFFFFFFF};
    {b.IReq, b.DReq, b.DWe, b.MAck} = 4'b0;
    {b.IAdr, b.DAdr, b.DWdata, b.MRdata} = '0;
    @(negedge clk);
    @(negedge clk);
    chk1("rst_mreq", b.MReq, 1'b0);
    chk1("rst_mwe", b.MWe, 1'b0);
    chk1("rst_ivalid", b.IValid, 1'b0);
    chk1("rst_dvalid", b.DValid, 1'b0);
    chk1("rst_terr", b.TimeoutErr, 1'b0);
    chk32("rst_madr", b.MAdr, 32'h0);
    chk32("rst_mwdata", b.MWdata, 32'h0);
    chk32("rst_irdata", b.IRdata, 32'h0);
    chk32("rst_drdata", b.DRdata, 32'h0);
    reset = 1'b0;
    foreach (vecs[i])
      run_txn(vecs[i].is_d, vecs[i].we, vecs[i].adr, vecs[i].wd, vecs[i].rd, vecs[i].waits, vecs[i].exp_rd);

    // simultaneous requests: data first, fetch on the following IDLE
    @(negedge clk);
    b.IReq = 1'b1; b.IAdr = 32'h300;
    b.DReq = 1'b1; b.DWe = 1'b0; b.DAdr = 32'h200;
    #1 chk1("dual_stall0", b.StallMem, 1'b1);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk1("dual_dmreq", b.MReq, 1'b1);
      chk32("dual_dadr", b.MAdr, 32'h200);
      chk1("dual_stall", b.StallMem, 1'b1);
      b.MAck = (i == 2);
      b.MRdata = 32'hD0D0D0D0;
    end
    @(negedge clk);
    b.MAck = 1'b0;
    chk1("dual_dvalid", b.DValid, 1'b1);
    chk1("dual_no_ivalid", b.IValid, 1'b0);
    chk32("dual_drdata", b.DRdata, 32'hD0D0D0D0);
    chk1("dual_stall_resp", b.StallMem, 1'b1);
    b.DReq = 1'b0;
    exp_dr = 32'hD0D0D0D0;
    @(negedge clk);
    chk1("dual_idle_gap", b.MReq, 1'b0);
    chk1("dual_stall_idle", b.StallMem, 1'b1);
    @(negedge clk);
    chk1("dual_imreq", b.MReq, 1'b1);
    chk32("dual_iadr", b.MAdr, 32'h300);
    chk1("dual_imwe", b.MWe, 1'b0);
    chk1("dual_stall_iacc", b.StallMem, 1'b1);
    b.MAck = 1'b1; b.MRdata = 32'h12340000;
    @(negedge clk);
    b.MAck = 1'b0;
    chk1("dual_ivalid", b.IValid, 1'b1);
    chk32("dual_irdata", b.IRdata, 32'h12340000);
    b.IReq = 1'b0;
    exp_ir = 32'h12340000;
    @(negedge clk);
    chk1("dual_stall_done", b.StallMem, 1'b0);

    // fetch request held across RESP: one IValid per access, IDLE gap between MReq pulses
    @(negedge clk);
    b.IReq = 1'b1; b.IAdr = 32'h400;
    rd1 = $urandom; rd2 = $urandom;
    for (int c = 1; c <= 6; c++) begin
      @(negedge clk);
      exp_mreq_v = {c == 2 || c == 5, c == 1 || c == 4};
      chk1("b2b_mreq", b.MReq, exp_mreq_v[0]);
      chk1("b2b_ivalid", b.IValid, exp_mreq_v[1]);
      if (c == 4) chk32("b2b_adr2", b.MAdr, 32'h404);
      if (c == 2) chk32("b2b_rd1", b.IRdata, rd1);
      if (c == 5) chk32("b2b_rd2", b.IRdata, rd2);
      b.MAck = b.MReq;
      b.MRdata = c < 3 ? rd1 : rd2;
      if (c == 2) b.IAdr = 32'h404;
      if (c == 5) b.IReq = 1'b0;
    end
    b.MAck = 1'b0;
    exp_ir = rd2;

    // random transactions checked against the model
    for (int t = 0; t < 40; t++) begin
      logic d, w;
      logic [31:0] rd;
      d = 1'($urandom_range(0, 1));
      w = 1'($urandom_range(0, 1));
      rd = $urandom;
      run_txn(d, w, $urandom, $urandom, rd, $urandom_range(0, 4), (d && w) ? exp_dr : rd);
    end

    // reset during DACC, then a stray MAck after release
    @(negedge clk);
    b.DReq = 1'b1; b.DWe = 1'b0; b.DAdr = 32'h500;
    @(negedge clk);
    chk1("rmid_mreq_before", b.MReq, 1'b1);
    #2 reset = 1'b1;
    #1;
    chk1("rmid_mreq_async", b.MReq, 1'b0);
    chk32("rmid_madr", b.MAdr, 32'h0);
    chk1("rmid_dvalid", b.DValid, 1'b0);
    b.DReq = 1'b0;
    @(negedge clk);
    reset = 1'b0;
    b.MAck = 1'b1; b.MRdata = 32'hBAD0BAD0;
    @(negedge clk);
    b.MAck = 1'b0;
    chk1("stray_dvalid", b.DValid, 1'b0);
    chk1("stray_mreq", b.MReq, 1'b0);
    @(negedge clk);
    chk1("stray_dvalid2", b.DValid, 1'b0);
    chk32("stray_drdata", b.DRdata, 32'h0);
    exp_dr = 32'h0;
    exp_ir = 32'h0;

    // MAck never arrives
    @(negedge clk);
    b.DReq = 1'b1; b.DWe = 1'b0; b.DAdr = 32'h600;
`ifdef MEM_ARB_TIMEOUT_EN
    n = 0;
    for (int i = 0; i < 40 && !b.DValid; i++) begin
      @(negedge clk);
      if (b.MReq) n++;
    end
    chk32("to_cycles", n, 32'd16);
    chk1("to_dvalid", b.DValid, 1'b1);
    chk32("to_drdata", b.DRdata, 32'hDEADBEEF);
    chk1("to_err", b.TimeoutErr, 1'b1);
    b.DReq = 1'b0;
    repeat (3) @(negedge clk);
    chk1("to_err_sticky", b.TimeoutErr, 1'b1);
    chk1("to_dvalid_once", b.DValid, 1'b0);
    reset = 1'b1;
    @(negedge clk);
    chk1("to_err_reset", b.TimeoutErr, 1'b0);
    reset = 1'b0;
`else
    n = 0;
    repeat (24) begin
      @(negedge clk);
      if (b.MReq && !b.DValid) n++;
    end
    chk32("wait_forever", n, 32'd24);
    chk1("no_terr", b.TimeoutErr, 1'b0);
    b.MAck = 1'b1; b.MRdata = 32'h0BADCAFE;
    @(negedge clk);
    b.MAck = 1'b0;
    chk1("late_dvalid", b.DValid, 1'b1);
    chk32("late_drdata", b.DRdata, 32'h0BADCAFE);
    b.DReq = 1'b0;
    @(negedge clk);
`endif
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
